// File: rtl/pov_pkg.sv
// Shared constants, the index-width helper and the scan-direction type
// used by the POV receiver sequencer.
package pov_pkg;

    localparam int POV_BITS_PER_CHAR  = 8;
    localparam int POV_CHARS_PER_STR  = 12;
    localparam int POV_STRS_PER_FRAME = 4;

    // A modulo-1 counter still needs one bit of storage.
    function automatic int pov_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    typedef enum logic {
        SCAN_DOWN = 1'b0,
        SCAN_UP   = 1'b1
    } scan_dir_e;

endpackage

// File: rtl/pov_wrap_counter.sv
// Modulo-N counter with enable, run-time direction, synchronous load to the
// start value and a registered one-cycle wrap pulse.
module pov_wrap_counter
    import pov_pkg::*;
#(
    parameter int N = 8,
    localparam int W = pov_width(N)
) (
    input  logic         clk_2,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic         dir,
    input  logic         next_dir,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] start_val;
    logic         at_end;

    // next_dir picks the restart point, so a wrap can also switch direction.
    always_comb begin
        start_val = (next_dir == SCAN_UP) ? '0 : LAST;
        at_end    = (dir == SCAN_UP) ? (cnt == LAST) : (cnt == '0);
    end

    always_ff @(posedge clk_2) begin
        if (reset || load) begin
            cnt  <= start_val;
            wrap <= 1'b0;
        end else begin
            wrap <= en & at_end;
            if (en) begin
                if (at_end)
                    cnt <= start_val;
                else if (dir == SCAN_UP)
                    cnt <= cnt + 1'b1;
                else
                    cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pov_scan_counter.sv
// Bit / character / line sequencer for the POV receiver: three cascaded
// wrap counters plus the direction register applied at each string boundary.
module pov_scan_counter
    import pov_pkg::*;
#(
    parameter int BITS_PER_CHAR  = POV_BITS_PER_CHAR,
    parameter int CHARS_PER_STR  = POV_CHARS_PER_STR,
    parameter int STRS_PER_FRAME = POV_STRS_PER_FRAME,
    localparam int BW = pov_width(BITS_PER_CHAR),
    localparam int CW = pov_width(CHARS_PER_STR),
    localparam int LW = pov_width(STRS_PER_FRAME)
) (
    input  logic          clk_2,
    input  logic          reset,
    input  logic          WriteChar,
    input  logic          WriteString,
    input  logic          scan_dir,
    input  logic          frame_sync,
    output logic [BW-1:0] bit_idx,
    output logic [CW-1:0] char_idx,
    output logic [LW-1:0] line_idx,
    output logic          char_done,
    output logic          str_done,
    output logic          frame_done,
    output logic          dir_q
);

    logic char_last;
    logic char_wrap;

    assign char_last = (dir_q == SCAN_UP) ? (char_idx == CW'(CHARS_PER_STR - 1))
                                          : (char_idx == '0);
    assign char_wrap = WriteString & char_last;

    // A new direction only takes hold where a fresh string starts.
    always_ff @(posedge clk_2) begin
        if (reset || frame_sync)
            dir_q <= scan_dir;
        else if (char_wrap)
            dir_q <= scan_dir;
    end

    pov_wrap_counter #(.N(BITS_PER_CHAR)) u_bit_cnt (
        .clk_2    (clk_2),
        .reset    (reset),
        .load     (frame_sync | ~WriteChar),
        .en       (WriteChar),
        .dir      (SCAN_DOWN),
        .next_dir (SCAN_DOWN),
        .cnt      (bit_idx),
        .wrap     (char_done)
    );

    pov_wrap_counter #(.N(CHARS_PER_STR)) u_char_cnt (
        .clk_2    (clk_2),
        .reset    (reset),
        .load     (frame_sync),
        .en       (WriteString),
        .dir      (dir_q),
        .next_dir (scan_dir),
        .cnt      (char_idx),
        .wrap     (str_done)
    );

    pov_wrap_counter #(.N(STRS_PER_FRAME)) u_line_cnt (
        .clk_2    (clk_2),
        .reset    (reset),
        .load     (frame_sync),
        .en       (char_wrap),
        .dir      (SCAN_UP),
        .next_dir (SCAN_UP),
        .cnt      (line_idx),
        .wrap     (frame_done)
    );

endmodule
